// File: rtl/fabric_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : fabric_ctrl_if
//  Description : Host command bus for fabric_ctrl (valid/ready handshake plus
//                INSTR / LAUNCH command fields).
//  Revision    : 1.0 - initial release
// ============================================================================
interface fabric_ctrl_if #(
  parameter int ROWS             = 2,
  parameter int ROW_W            = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int INSTR_DATA_WIDTH = 27,
  parameter int INSTR_ADDR_WIDTH = 4,
  parameter int INSTR_HOPS_WIDTH = 4
) ();

  logic                        cmd_valid;
  logic                        cmd_ready;
  logic                        cmd_type;   // 0 = INSTR, 1 = LAUNCH
  logic [ROW_W-1:0]            cmd_row;
  logic [ROWS-1:0]             cmd_mask;
  logic [INSTR_HOPS_WIDTH-1:0] cmd_hops;
  logic [INSTR_ADDR_WIDTH-1:0] cmd_addr;
  logic [INSTR_DATA_WIDTH-1:0] cmd_data;

  // Host side drives the command, controller answers with ready
  modport master (
    output cmd_valid, cmd_type, cmd_row, cmd_mask, cmd_hops, cmd_addr, cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_row, cmd_mask, cmd_hops, cmd_addr, cmd_data,
    output cmd_ready
  );

endinterface
`default_nettype wire

// File: rtl/fabric_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fabric_ctrl
//  Description : Host-side sequencer for a ROWS-row fabric. Buffers host
//                commands in an in-order FIFO, streams INSTR words onto a
//                row's instruction chain and launches rows via call/ret with
//                a per-row guard/run tracker.
//  Revision    : 1.0 - initial release
// ============================================================================
module fabric_ctrl #(
  parameter int ROWS             = 2,
  parameter int INSTR_DATA_WIDTH = 27,
  parameter int INSTR_ADDR_WIDTH = 4,
  parameter int INSTR_HOPS_WIDTH = 4,
  parameter int FIFO_DEPTH       = 4,
  parameter int RET_GUARD        = 2,
  parameter int ROW_W            = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  fabric_ctrl_if.slave                             cmd,
  output logic [ROWS-1:0]                          o_instr_en_out,
  output logic [ROWS-1:0][INSTR_DATA_WIDTH-1:0]    o_instr_data_out,
  output logic [ROWS-1:0][INSTR_ADDR_WIDTH-1:0]    o_instr_addr_out,
  output logic [ROWS-1:0][INSTR_HOPS_WIDTH-1:0]    o_instr_hops_out,
  output logic [ROWS-1:0]                          o_call,
  input  logic [ROWS-1:0]                          i_ret,
  output logic [ROWS-1:0]                          o_busy,
  output logic [ROWS-1:0]                          o_done,
  output logic                                     o_err
);

  localparam int C_AW = $clog2(FIFO_DEPTH);
  localparam int C_GW = (RET_GUARD > 0) ? $clog2(RET_GUARD + 1) : 1;

  localparam logic [C_AW:0]   C_PTR_ONE    = 1;
  localparam logic [C_GW-1:0] C_CNT_ONE    = 1;
  localparam logic [C_GW-1:0] C_GUARD_INIT = C_GW'(RET_GUARD);

  // Per-row tracker states
  localparam logic [1:0] C_ST_IDLE  = 2'd0;
  localparam logic [1:0] C_ST_GUARD = 2'd1;
  localparam logic [1:0] C_ST_RUN   = 2'd2;

  typedef struct packed {
    logic                        typ;
    logic [ROW_W-1:0]            row;
    logic [ROWS-1:0]             mask;
    logic [INSTR_HOPS_WIDTH-1:0] hops;
    logic [INSTR_ADDR_WIDTH-1:0] addr;
    logic [INSTR_DATA_WIDTH-1:0] data;
  } cmd_t;

  cmd_t            r_fifo [FIFO_DEPTH];
  logic [C_AW:0]   r_wr_ptr;
  logic [C_AW:0]   r_rd_ptr;
  logic            r_live;
  logic [ROWS-1:0] r_en;
  logic [ROWS-1:0] r_call;
  logic            r_err;

  logic            w_empty;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  cmd_t            w_in;
  cmd_t            w_head;
  logic [ROWS-1:0] w_row_sel;
  logic            w_row_ok;
  logic [ROWS-1:0] w_busy;
  logic [ROWS-1:0] w_launch;
  logic            w_illegal;
  logic            w_instr_go;
  logic            w_launch_go;

  // --------------------------------------------------------------------------
  // Command FIFO: extra pointer MSB separates full from empty. Ready is held
  // low until the first clock after reset releases.
  // --------------------------------------------------------------------------
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[C_AW] != r_rd_ptr[C_AW]) &&
                   (r_wr_ptr[C_AW-1:0] == r_rd_ptr[C_AW-1:0]);
  assign cmd.cmd_ready = r_live && !w_full;
  assign w_push  = cmd.cmd_valid && cmd.cmd_ready;

  assign w_in.typ  = cmd.cmd_type;
  assign w_in.row  = cmd.cmd_row;
  assign w_in.mask = cmd.cmd_mask;
  assign w_in.hops = cmd.cmd_hops;
  assign w_in.addr = cmd.cmd_addr;
  assign w_in.data = cmd.cmd_data;

  assign w_head = r_fifo[r_rd_ptr[C_AW-1:0]];

  // Pointer and ready-enable registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_live   <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr[C_AW-1:0]] <= w_in;
  end

  // --------------------------------------------------------------------------
  // Head dispatch. The one-hot shift yields zero for out-of-range rows, so an
  // illegal row never aliases onto a real one.
  // --------------------------------------------------------------------------
  assign w_row_sel = ROWS'(1) << w_head.row;
  assign w_row_ok  = (32'(w_head.row) < ROWS);

  // Decide whether the head pops this cycle and what it does
  always_comb begin
    w_illegal   = 1'b0;
    w_instr_go  = 1'b0;
    w_launch_go = 1'b0;
    if (!w_empty) begin
      if (w_head.typ) begin
        if (w_head.mask == '0)                  w_illegal   = 1'b1;
        else if ((w_head.mask & w_busy) == '0)  w_launch_go = 1'b1;
      end else begin
        if (!w_row_ok)                          w_illegal   = 1'b1;
        else if ((w_row_sel & w_busy) == '0)    w_instr_go  = 1'b1;
      end
    end
  end

  assign w_pop    = w_illegal | w_instr_go | w_launch_go;
  assign w_launch = w_launch_go ? w_head.mask : '0;

  // Strobes, call pulses and sticky error flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_en   <= '0;
      r_call <= '0;
      r_err  <= 1'b0;
    end else begin
      r_en   <= w_instr_go ? w_row_sel : '0;
      r_call <= w_launch;
      r_err  <= r_err | w_illegal;
    end
  end

  assign o_instr_en_out = r_en;
  assign o_call         = r_call;
  assign o_err          = r_err;
  assign o_busy         = w_busy;

  // --------------------------------------------------------------------------
  // Per-row instruction registers and launch tracker
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    logic [INSTR_DATA_WIDTH-1:0] r_data;
    logic [INSTR_ADDR_WIDTH-1:0] r_addr;
    logic [INSTR_HOPS_WIDTH-1:0] r_hops;
    logic [1:0]                  r_state;
    logic [1:0]                  w_state_nxt;
    logic [C_GW-1:0]             r_cnt;
    logic [C_GW-1:0]             w_cnt_nxt;
    logic                        r_done;
    logic                        w_done_nxt;
    logic                        w_busy_row;

    // Instruction fields load only when this row is dispatched, else hold
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_data <= '0;
        r_addr <= '0;
        r_hops <= '0;
      end else if (w_instr_go && w_row_sel[gi]) begin
        r_data <= w_head.data;
        r_addr <= w_head.addr;
        r_hops <= w_head.hops;
      end
    end

    // Tracker state register
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_state <= C_ST_IDLE;
        r_cnt   <= '0;
        r_done  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_done  <= w_done_nxt;
      end
    end

    // Tracker next state: ret is ignored while the guard counts down to zero
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
        C_ST_IDLE: begin
          if (w_launch[gi]) begin
            w_state_nxt = C_ST_GUARD;
            w_cnt_nxt   = C_GUARD_INIT;
          end
        end
        C_ST_GUARD: begin
          if (r_cnt == '0) w_state_nxt = C_ST_RUN;
          else             w_cnt_nxt   = r_cnt - C_CNT_ONE;
        end
        C_ST_RUN: begin
          if (i_ret[gi]) w_state_nxt = C_ST_IDLE;
        end
        default: w_state_nxt = C_ST_IDLE;
      endcase
    end

    // Tracker outputs: busy from state, done registered on the completing edge
    always_comb begin
      w_busy_row = (r_state != C_ST_IDLE);
      w_done_nxt = (r_state == C_ST_RUN) && i_ret[gi];
    end

    assign w_busy[gi]           = w_busy_row;
    assign o_done[gi]           = r_done;
    assign o_instr_data_out[gi] = r_data;
    assign o_instr_addr_out[gi] = r_addr;
    assign o_instr_hops_out[gi] = r_hops;
  end

endmodule
`default_nettype wire

// File: tb/tb_fabric_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fabric_ctrl
//  Description : Self-checking bench for fabric_ctrl (ROWS=3 so that an
//                out-of-range row index is expressible).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fabric_ctrl;

  localparam int ROWS  = 3;
  localparam int ROW_W = 2;
  localparam int DW    = 27;
  localparam int AW    = 4;
  localparam int HW    = 4;
  localparam int DEPTH = 4;
  localparam int RG    = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [ROWS-1:0]          ret;
  logic [ROWS-1:0]          en, call, busy, done;
  logic                     err;
  logic [ROWS-1:0][DW-1:0]  d_out;
  logic [ROWS-1:0][AW-1:0]  a_out;
  logic [ROWS-1:0][HW-1:0]  h_out;

  fabric_ctrl_if #(.ROWS(ROWS), .ROW_W(ROW_W), .INSTR_DATA_WIDTH(DW),
                   .INSTR_ADDR_WIDTH(AW), .INSTR_HOPS_WIDTH(HW)) bus ();

  fabric_ctrl #(.ROWS(ROWS), .INSTR_DATA_WIDTH(DW), .INSTR_ADDR_WIDTH(AW),
                .INSTR_HOPS_WIDTH(HW), .FIFO_DEPTH(DEPTH), .RET_GUARD(RG),
                .ROW_W(ROW_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cmd              (bus),
    .o_instr_en_out   (en),
    .o_instr_data_out (d_out),
    .o_instr_addr_out (a_out),
    .o_instr_hops_out (h_out),
    .o_call           (call),
    .i_ret            (ret),
    .o_busy           (busy),
    .o_done           (done),
    .o_err            (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit              typ;
    bit [ROW_W-1:0]  row;
    bit [ROWS-1:0]   mask;
    bit [HW-1:0]     hops;
    bit [AW-1:0]     addr;
    bit [DW-1:0]     data;
  } cmd_t;

  typedef struct {
    cmd_t            c;
    bit [ROWS-1:0]   exp_en;
    bit [ROWS-1:0]   exp_call;
    bit              exp_err;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: command queue, per-row busy flag and the cycle from
  // which the row will honour ret, plus the expected output values.
  cmd_t          m_q[$];
  bit            m_live;
  bit [ROWS-1:0] m_busy, m_en, m_call, m_done;
  bit            m_err;
  int            m_run_from [ROWS];
  bit [DW-1:0]   m_data [ROWS];
  bit [AW-1:0]   m_addr [ROWS];
  bit [HW-1:0]   m_hops [ROWS];
  int            cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic cmd_t instr(bit [ROW_W-1:0] r, bit [HW-1:0] h, bit [AW-1:0] a, bit [DW-1:0] d);
    cmd_t c;
    c.typ = 1'b0; c.row = r; c.mask = '0; c.hops = h; c.addr = a; c.data = d;
    return c;
  endfunction

  function automatic cmd_t launch(bit [ROWS-1:0] m);
    cmd_t c;
    c.typ = 1'b1; c.row = '0; c.mask = m; c.hops = '0; c.addr = '0; c.data = '0;
    return c;
  endfunction

  task automatic drive(input cmd_t c);
    bus.cmd_valid = 1'b1;
    bus.cmd_type  = c.typ;
    bus.cmd_row   = c.row;
    bus.cmd_mask  = c.mask;
    bus.cmd_hops  = c.hops;
    bus.cmd_addr  = c.addr;
    bus.cmd_data  = c.data;
  endtask

  task automatic idle();
    bus.cmd_valid = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently applied
  function automatic void model_step();
    cmd_t          h, cur;
    bit [ROWS-1:0] nbusy, ndone, nen, ncall;
    bit            pop, ready, push;
    ready = m_live && (m_q.size() < DEPTH);
    push  = bus.cmd_valid && ready;
    if (!rst_n) begin
      m_q.delete();
      m_live = 0; m_busy = '0; m_en = '0; m_call = '0; m_done = '0; m_err = 0;
      for (int i = 0; i < ROWS; i++) begin
        m_data[i] = '0; m_addr[i] = '0; m_hops[i] = '0; m_run_from[i] = 0;
      end
      cyc++;
      return;
    end
    nbusy = m_busy; ndone = '0; nen = '0; ncall = '0; pop = 0;
    for (int i = 0; i < ROWS; i++)
      if (m_busy[i] && cyc >= m_run_from[i] && ret[i]) begin
        nbusy[i] = 0;
        ndone[i] = 1;
      end
    if (m_q.size() > 0) begin
      h = m_q[0];
      if (h.typ) begin
        if (h.mask == '0) begin
          pop = 1; m_err = 1;
        end else if ((h.mask & m_busy) == '0) begin
          pop = 1; ncall = h.mask;
          for (int i = 0; i < ROWS; i++)
            if (h.mask[i]) begin
              nbusy[i] = 1;
              m_run_from[i] = cyc + 1 + RG + 1;
            end
        end
      end else begin
        if (int'(h.row) >= ROWS) begin
          pop = 1; m_err = 1;
        end else if (!m_busy[h.row]) begin
          pop = 1;
          nen[h.row] = 1;
          m_data[h.row] = h.data;
          m_addr[h.row] = h.addr;
          m_hops[h.row] = h.hops;
        end
      end
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      cur.typ = bus.cmd_type; cur.row = bus.cmd_row; cur.mask = bus.cmd_mask;
      cur.hops = bus.cmd_hops; cur.addr = bus.cmd_addr; cur.data = bus.cmd_data;
      m_q.push_back(cur);
    end
    m_live = 1; m_busy = nbusy; m_en = nen; m_call = ncall; m_done = ndone;
    cyc++;
  endfunction

  task automatic check_all();
    chk("cmd_ready", bus.cmd_ready, m_live && (m_q.size() < DEPTH));
    chk("instr_en", en, m_en);
    chk("call", call, m_call);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("err", err, m_err);
    for (int i = 0; i < ROWS; i++) begin
      chk("instr_data", d_out[i], m_data[i]);
      chk("instr_addr", a_out[i], m_addr[i]);
      chk("instr_hops", h_out[i], m_hops[i]);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vec [7];
    bit   got;

    vec[0] = '{instr(2'd0, 4'd3, 4'd5, 27'h1234567), 3'b001, 3'b000, 1'b0};
    vec[1] = '{instr(2'd1, 4'hF, 4'h0, 27'h7FFFFFF), 3'b010, 3'b000, 1'b0};
    vec[2] = '{instr(2'd2, 4'h1, 4'hA, 27'h0000000), 3'b100, 3'b000, 1'b0};
    vec[3] = '{launch(3'b101),                        3'b000, 3'b101, 1'b0};
    vec[4] = '{instr(2'd3, 4'h2, 4'h2, 27'h0222222), 3'b000, 3'b000, 1'b1};
    vec[5] = '{launch(3'b000),                        3'b000, 3'b000, 1'b1};
    vec[6] = '{instr(2'd0, 4'h9, 4'h6, 27'h5555555), 3'b001, 3'b000, 1'b1};

    // Reset
    rst_n = 1'b0; ret = '0;
    bus.cmd_valid = 1'b0; bus.cmd_type = 1'b0; bus.cmd_row = '0; bus.cmd_mask = '0;
    bus.cmd_hops = '0; bus.cmd_addr = '0; bus.cmd_data = '0;
    tick(); tick();
    chk("reset_ready", bus.cmd_ready, 1'b0);
    chk("reset_busy", busy, 3'b000);
    rst_n = 1'b1;
    tick();
    chk("ready_after_reset", bus.cmd_ready, 1'b1);

    // Single-command vectors, each from an idle controller
    ret = 3'b111;
    for (int k = 0; k < 7; k++) begin
      drive(vec[k].c);
      tick();
      idle();
      chk("tbl_en_early", en, 3'b000);
      tick();
      chk("tbl_en", en, vec[k].exp_en);
      chk("tbl_call", call, vec[k].exp_call);
      chk("tbl_err", err, vec[k].exp_err);
      if (vec[k].exp_en != '0) begin
        chk("tbl_data", d_out[vec[k].c.row], vec[k].c.data);
        chk("tbl_addr", a_out[vec[k].c.row], vec[k].c.addr);
        chk("tbl_hops", h_out[vec[k].c.row], vec[k].c.hops);
      end
      tick();
      chk("tbl_en_pulse", en, 3'b000);
      chk("tbl_call_pulse", call, 3'b000);
      for (int j = 0; j < 10 && busy != '0; j++) tick();
      chk("tbl_drain", busy, 3'b000);
    end

    // Back-to-back INSTRs alternating rows
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    drive(instr(2'd0, 4'd1, 4'd1, 27'h0000011)); tick(); chk("b2b_en0", en, 3'b000);
    drive(instr(2'd1, 4'd2, 4'd2, 27'h0000022)); tick(); chk("b2b_en1", en, 3'b001);
    drive(instr(2'd0, 4'd3, 4'd3, 27'h0000033)); tick(); chk("b2b_en2", en, 3'b010);
    drive(instr(2'd1, 4'd4, 4'd4, 27'h0000044)); tick(); chk("b2b_en3", en, 3'b001);
    chk("b2b_ready", bus.cmd_ready, 1'b1);
    idle(); tick(); chk("b2b_en4", en, 3'b010);
    chk("b2b_data1", d_out[1], 27'h0000044);
    tick(); chk("b2b_en5", en, 3'b000);

    // Launch both rows with ret high throughout: done 4 cycles after call
    drive(launch(3'b011)); tick(); idle(); tick();
    chk("lc_call", call, 3'b011);
    chk("lc_busy", busy, 3'b011);
    for (int j = 1; j <= 4; j++) begin
      tick();
      chk("lc_call_off", call, 3'b000);
      chk("lc_done", done, (j == 4) ? 3'b011 : 3'b000);
    end
    tick(); chk("lc_done_pulse", done, 3'b000);

    // Busy interlock and in-order hold
    ret = 3'b110;
    drive(launch(3'b001)); tick();
    drive(instr(2'd0, 4'd7, 4'd8, 27'h0ABCDEF)); tick();
    drive(instr(2'd1, 4'd6, 4'd9, 27'h0FEDCBA)); tick();
    idle();
    for (int j = 0; j < 20; j++) begin
      tick();
      chk("il_hold_en", en, 3'b000);
    end
    ret = 3'b111;
    got = 1'b0;
    for (int j = 0; j < 12 && !got; j++) begin
      tick();
      if (done[0]) got = 1'b1;
    end
    chk("il_done_seen", got, 1'b1);
    chk("il_en_at_done", en, 3'b000);
    tick(); chk("il_en_row0", en, 3'b001); chk("il_data_row0", d_out[0], 27'h0ABCDEF);
    tick(); chk("il_en_row1", en, 3'b010); chk("il_data_row1", d_out[1], 27'h0FEDCBA);

    // Fill the FIFO behind a busy row, then reset mid-operation
    ret = 3'b110;
    drive(launch(3'b001)); tick(); idle(); tick();
    for (int j = 0; j < 4; j++) begin
      drive(instr(2'd0, 4'(j), 4'(j), 27'(j + 100)));
      tick();
    end
    chk("fill_ready", bus.cmd_ready, 1'b0);
    tick();
    chk("fill_ready_held", bus.cmd_ready, 1'b0);
    idle();
    rst_n = 1'b0; tick();
    chk("mid_rst_busy", busy, 3'b000);
    chk("mid_rst_en", en, 3'b000);
    chk("mid_rst_call", call, 3'b000);
    chk("mid_rst_ready", bus.cmd_ready, 1'b0);
    rst_n = 1'b1; ret = 3'b111;
    for (int j = 0; j < 10; j++) begin
      tick();
      chk("mid_rst_quiet", {en, call, done}, 9'd0);
    end
    chk("mid_rst_ready_back", bus.cmd_ready, 1'b1);

    // Randomised traffic against the model
    for (int j = 0; j < 2500; j++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      for (int i = 0; i < ROWS; i++) ret[i] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 1) == 1)
          drive(launch(3'($urandom_range(0, 7))));
        else
          drive(instr(($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                      4'($urandom), 4'($urandom), 27'($urandom)));
      end else begin
        idle();
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fabric_ctrl.md
Name: fabric_ctrl

Overview:
Host-side sequencer for a ROWS-row fabric array. It accepts a stream of commands from a host on a valid/ready interface and buffers them in an in-order FIFO. Instruction commands are dispatched onto one row's instruction-chain input, one per cycle. Launch commands pulse the call lines of selected rows and track each row's ret to completion. It sits between the host/configuration logic and the fabric's per-row call/ret and instr_* ports.

Parameters:
ROWS, 2, number of fabric rows controlled
INSTR_DATA_WIDTH, 27, instruction word width
INSTR_ADDR_WIDTH, 4, cell-local instruction address width
INSTR_HOPS_WIDTH, 4, hop-count field width
FIFO_DEPTH, 4, command FIFO entries; power of 2, >=2
RET_GUARD, 2, cycles after call during which ret is ignored; >=1
ROW_W, $clog2(ROWS) (min 1), derived row-index width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  FIFO not full
cmd_type  in  1  0=INSTR, 1=LAUNCH
cmd_row  in  ROW_W  target row (INSTR)
cmd_mask  in  ROWS  rows to launch (LAUNCH)
cmd_hops  in  INSTR_HOPS_WIDTH  hop count (INSTR)
cmd_addr  in  INSTR_ADDR_WIDTH  instruction address (INSTR)
cmd_data  in  INSTR_DATA_WIDTH  instruction word (INSTR)
instr_en_out  out  ROWS  per-row instruction strobe to fabric
instr_data_out  out  ROWS x INSTR_DATA_WIDTH  to fabric instr_data_in
instr_addr_out  out  ROWS x INSTR_ADDR_WIDTH  to fabric instr_addr_in
instr_hops_out  out  ROWS x INSTR_HOPS_WIDTH  to fabric instr_hops_in
call  out  ROWS  per-row start pulse to fabric
ret  in  ROWS  per-row completion level from fabric
busy  out  ROWS  row launched, not yet complete
done  out  ROWS  one-cycle pulse when a row completes
err  out  1  sticky: illegal command dropped

Behaviour:
- Reset is rst_n, synchronous, active-low. It clears the FIFO and sends all row FSMs to IDLE. The following are all 0 after reset: cmd_ready (rises the cycle after rst_n deasserts), instr_en_out, instr_data_out, instr_addr_out, instr_hops_out, call, busy, done, err. Reset mid-operation aborts everything; queued and in-flight commands are discarded.
- Accept: a command is accepted on a rising edge where cmd_valid && cmd_ready.
- cmd_ready = !full. Push and pop in the same cycle are legal when not full.
- The FIFO is in-order and uses wrap-around pointers with an extra MSB to distinguish full from empty.
- Head dispatch is evaluated every cycle; at most one command is popped per cycle. All fabric-side outputs are registered.
- INSTR head, row r:
  - If busy[r]=0, pop. Next cycle: instr_en_out[r]=1, and r's data/addr/hops carry the command fields.
  - All other rows have en=0. Data/addr/hops on non-selected rows hold their previous values.
  - If busy[r]=1, stall; the head stays and nothing else is dispatched.
- LAUNCH head, mask m:
  - If (m & busy)==0, pop. Next cycle: call[i]=1 for each i in m, for exactly one cycle.
  - Otherwise stall.
- Latency: command accepted at edge t into an empty FIFO with its row idle appears on the fabric outputs in the cycle after edge t+1 (2 edges).
- Illegal commands are popped and dropped with no fabric effect, and err is set. err clears only on reset. Illegal means:
  - INSTR with cmd_row >= ROWS.
  - LAUNCH with m==0.
- Per-row FSM:
  - IDLE -> GUARD on the launch pop: busy=1, guard counter = RET_GUARD.
  - GUARD: the counter decrements each cycle and ret is ignored. At 0 -> RUN.
  - RUN: when ret[i]==1 -> IDLE, busy=0, done[i]=1 for one cycle.
  - Minimum launch-to-done time is RET_GUARD+2 cycles.
- Busy interlock: a LAUNCH or INSTR targeting a busy row may be at the head in the same cycle that row goes IDLE. It is dispatched the following cycle; busy is sampled as a registered value.
- Row independence: rows run independently. A LAUNCH for row 1 may dispatch while row 0 is busy, provided its mask excludes row 0.
- Ordering: an INSTR queued behind a LAUNCH of the same row is not dispatched before that row's done.

Test Plan:
- Reset, single INSTR: reset, then INSTR row0 hops=3 addr=5 data=0x1234567 -> instr_en_out=2'b01 exactly one cycle, 2 edges after accept, with fields matching; cmd_ready=1 throughout.
- Back-to-back INSTRs: 4 INSTRs alternating row0/row1 back-to-back -> en pattern 01,10,01,10 on consecutive cycles; with the host stalled, the 5th push sees cmd_ready=0 only if the FIFO fills.
- Launch and complete: LAUNCH mask=2'b11 with RET_GUARD=2; ret forced 1 throughout -> call=11 for one cycle, busy=11, done=11 pulse 4 cycles after the call cycle; ret ignored during guard.
- Busy interlock: LAUNCH row0, then INSTR row0, then INSTR row1, with ret[0] low for 20 cycles -> INSTR row0 is held; instr_en_out stays 0 until one cycle after done[0]; the row1 INSTR waits behind it (in-order).
- Illegal commands: with ROWS=3, INSTR cmd_row=3, and LAUNCH mask=0 -> no en/call activity, err=1 and sticky; a following legal INSTR dispatches normally.
- Reset mid-operation: rst_n low for 1 cycle with FIFO holding 3 entries and row0 busy -> next cycle busy=0, call=0, instr_en_out=0, FIFO empty, no done pulse; queued commands never appear.
